pomo_cycle_engine: RTL
======================

// Module: pomo_cycle_engine
// PURPOSE
//  Next-generation Pomodoro countdown core. Sequences WORK / SHORT-break / LONG-break phases with
//  per-phase preset durations, pause/resume and a minute-set mode. Emits registered 2-digit BCD
//  minutes/seconds, a blink enable and phase status to the 7-segment display driver.
//  Sits between the debounced lever/button pulse inputs and the display mux.
// PARAMETERS
//  TICK_CLKS   1000000  clocks per 1 s countdown tick (>=2)
//  BLINK_CLKS  500000   clocks per blink half-period (>=1)
//  WORK_MIN    25       WORK preset, minutes (1..MAX_MIN)
//  SHORT_MIN   5        SHORT-break preset, minutes (1..MAX_MIN)
//  LONG_MIN    15       LONG-break preset, minutes (1..MAX_MIN)
//  LONG_EVERY  4        completed WORK phases per LONG break (1..15)
//  MAX_MIN     59       set-mode wrap value (<=99)
//  AUTO_ADV    0        1: on expiry go straight to RUN of next phase after one blink period
// PORTS
//  clk        in   1  system clock
//  rst        in   1  asynchronous, active-high reset
//  lever      in   1  one-clock pulse: start/pause/resume; decrement in SET
//  button     in   1  one-clock pulse: enter/leave SET, abort from PAUSE, ack expiry
//  min_bcd    out  8  minutes, BCD {tens,units}
//  sec_bcd    out  8  seconds, BCD {tens,units}
//  blink_7sd  out  1  display blank phase (1 = blank)
//  phase      out  2  00 WORK, 01 SHORT, 10 LONG
//  work_done  out  4  completed WORK phases mod LONG_EVERY
//  alarm      out  1  one-clock pulse on reaching 00:00 in RUN
// BEHAVIOUR
//  Reset: state IDLE, phase WORK, minutes=WORK_MIN, seconds=0, work_done=0, clk_cnt=0, blink_7sd=0,
//   alarm=0; min_bcd/sec_bcd = BCD(WORK_MIN)/00 immediately (combinational reset value).
//  BCD outputs are registered from binary minutes/seconds; latency exactly 1 clk after any change.
//  lever has priority over button when both pulse in the same cycle; button is then ignored.
//  IDLE: blink_7sd=0. lever -> RUN (clk_cnt=0). button -> SET.
//  RUN: clk_cnt counts 0..TICK_CLKS-1; at TICK_CLKS-1 decrement mm:ss (ss 0 -> 59 with mm-1),
//   clk_cnt=0. When mm:ss==00:00 (checked before counting) -> EXPIRED, alarm=1 that cycle.
//   lever -> PAUSE; clk_cnt and mm:ss held (resume continues the partial second).
//  PAUSE: blink toggles every BLINK_CLKS clks. lever -> RUN. button -> IDLE, reload current preset.
//  SET: blink toggles; seconds forced 0; lever: mm = (mm==0) ? MAX_MIN : mm-1. button -> IDLE.
//   Set value overrides the preset for the current phase only; next phase loads its preset.
//  EXPIRED: display 00:00 blinking. lever or button (or, with AUTO_ADV=1, first blink-period end)
//   -> advance phase, load its preset, go IDLE (AUTO_ADV=1: RUN).
//  Phase advance: WORK -> work_done+1; if new value == LONG_EVERY then work_done=0, phase=LONG,
//   else phase=SHORT. SHORT/LONG -> WORK.
//  blink_7sd forced 0 on every exit from PAUSE/SET/EXPIRED; blink counter cleared on entry.
//  Entering RUN at 00:00 (set to 0 in SET) -> EXPIRED on the next clk, no tick consumed.
//  rst asserted mid-RUN: all state returns to reset values asynchronously; no alarm emitted.
//  Illegal state encoding -> IDLE next clk. Counter widths via $clog2 of TICK_CLKS / BLINK_CLKS.
// STRUCTURE
//  pomo_defs.vh: state one-hot localparams (IDLE/RUN/PAUSE/SET/EXPIRED), phase codes, BCD macro.
//  Sub-module pomo_bin2bcd99: single-cycle registered 0..99 binary -> 2-digit BCD; instanced twice.
//  Main FSM, prescaler and blink counter live in this module.
// TESTING (TICK_CLKS=4, BLINK_CLKS=2, WORK_MIN=1, SHORT_MIN=1, LONG_MIN=2, LONG_EVERY=2)
//  Reset then lever -> 01:00, 00:59 after 4 clks, ... 00:00 after 240 clks, alarm 1 clk, phase stays 00.
//  Lever mid-second (clk_cnt=2), wait 20 clks, lever -> next decrement 2 clks after resume; blink toggles/2.
//  Two full WORK cycles with acks -> phase 01 then 10, work_done 1 then 0; LONG shows 02:00.
//  SET from 01:00, lever x2 -> 59:00 (wrap), button -> IDLE showing 59:00, blink_7sd=0.
//  SET to 00, button, lever -> EXPIRED next clk, alarm pulse, display 00:00 blinking.
//  lever+button same clk in IDLE -> RUN only; rst mid-RUN -> IDLE, 01:00, work_done=0, no alarm.

Source files
------------

// File: rtl/pomo_cycle_engine_pkg.sv
// rtl/pomo_cycle_engine_pkg.sv - shared types and helpers for the Pomodoro cycle engine
// Purpose: one-hot FSM state codes, phase codes, seconds wrap value and the
//          0..99 binary to 2-digit BCD conversion used by the display registers.
// Ports:   none (package)
package pomo_cycle_engine_pkg;

  typedef enum logic [4:0] {
    ST_IDLE    = 5'b00001,
    ST_RUN     = 5'b00010,
    ST_PAUSE   = 5'b00100,
    ST_SET     = 5'b01000,
    ST_EXPIRED = 5'b10000
  } state_e;

  typedef enum logic [1:0] {
    PH_WORK  = 2'b00,
    PH_SHORT = 2'b01,
    PH_LONG  = 2'b10
  } phase_e;

  localparam logic [5:0] SEC_WRAP = 6'd59;

  // {tens, units}; callers keep the input within 0..99
  function automatic logic [7:0] to_bcd99(input logic [6:0] bin);
    return {4'(bin / 7'd10), 4'(bin % 7'd10)};
  endfunction

endpackage

// File: rtl/pomo_cycle_engine_if.sv
// rtl/pomo_cycle_engine_if.sv - control/display bundle of the Pomodoro cycle engine
// Purpose: groups the debounced pulse inputs and the display/status outputs.
// Signals: lever, button (pulses into the engine); min_bcd, sec_bcd, blink_7sd,
//          phase, work_done, alarm (out of the engine).
// Modports: master = pulse source / display side, slave = engine.
interface pomo_cycle_engine_if;
  logic       lever;
  logic       button;
  logic [7:0] min_bcd;
  logic [7:0] sec_bcd;
  logic       blink_7sd;
  logic [1:0] phase;
  logic [3:0] work_done;
  logic       alarm;

  modport master (
    output lever, button,
    input  min_bcd, sec_bcd, blink_7sd, phase, work_done, alarm
  );

  modport slave (
    input  lever, button,
    output min_bcd, sec_bcd, blink_7sd, phase, work_done, alarm
  );
endinterface

// File: rtl/pomo_cycle_engine_bin2bcd99.sv
// rtl/pomo_cycle_engine_bin2bcd99.sv - registered 0..99 binary to 2-digit BCD
// Purpose: one-cycle registered conversion; reset value is the BCD of RST_BIN so
//          the display shows a sensible value while reset is held.
// Ports: clk, rst (async, active-high), bin [6:0] in, bcd [7:0] out {tens,units}.
module pomo_cycle_engine_bin2bcd99
  import pomo_cycle_engine_pkg::*;
#(
  parameter logic [6:0] RST_BIN = 7'd0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] bin,
  output logic [7:0] bcd
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bcd <= to_bcd99(RST_BIN);
    end else begin
      bcd <= to_bcd99(bin);
    end
  end

endmodule

// File: rtl/pomo_cycle_engine.sv
// rtl/pomo_cycle_engine.sv - Pomodoro countdown core (WORK/SHORT/LONG phases)
// Purpose: sequences work and break phases with preset durations, pause/resume,
//          minute-set mode and expiry handling; drives registered BCD mm:ss,
//          blink enable and phase status to the 7-segment driver.
// Ports: clk, rst (async, active-high)
//        bus (slave): lever, button in; min_bcd, sec_bcd, blink_7sd, phase,
//                     work_done, alarm out.
module pomo_cycle_engine
  import pomo_cycle_engine_pkg::*;
#(
  parameter int TICK_CLKS  = 1000000,
  parameter int BLINK_CLKS = 500000,
  parameter int WORK_MIN   = 25,
  parameter int SHORT_MIN  = 5,
  parameter int LONG_MIN   = 15,
  parameter int LONG_EVERY = 4,
  parameter int MAX_MIN    = 59,
  parameter int AUTO_ADV   = 0
) (
  input  logic clk,
  input  logic rst,
  pomo_cycle_engine_if.slave bus
);

  localparam int TW = (TICK_CLKS > 1) ? $clog2(TICK_CLKS) : 1;
  localparam int BW = (BLINK_CLKS > 1) ? $clog2(BLINK_CLKS) : 1;
  localparam logic [TW-1:0] TICK_LAST  = TW'(TICK_CLKS - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_CLKS - 1);

  state_e        state, state_n;
  phase_e        phase, phase_n;
  logic [6:0]    mm, mm_n;
  logic [5:0]    ss, ss_n;
  logic [TW-1:0] clk_cnt, clk_cnt_n;
  logic [BW-1:0] blink_cnt, blink_cnt_n;
  logic          blink, blink_n;
  logic [3:0]    work_done, work_done_n;
  logic          alarm, alarm_n;

  logic          at_zero;
  logic          blink_wrap;
  logic [BW-1:0] blink_cnt_step;
  logic          blink_step;
  logic [3:0]    work_inc;
  logic          advance;
  logic [7:0]    min_bcd, sec_bcd;

  function automatic logic [6:0] preset(input phase_e p);
    case (p)
      PH_SHORT: return 7'(SHORT_MIN);
      PH_LONG:  return 7'(LONG_MIN);
      default:  return 7'(WORK_MIN);
    endcase
  endfunction

  assign at_zero        = (mm == 7'd0) && (ss == 6'd0);
  assign blink_wrap     = (blink_cnt == BLINK_LAST);
  assign blink_cnt_step = blink_wrap ? '0 : blink_cnt + BW'(1);
  assign blink_step     = blink_wrap ? ~blink : blink;
  assign work_inc       = work_done + 4'd1;
  // auto-advance fires at the end of the first full blink period (second toggle)
  assign advance        = bus.lever || bus.button ||
                          ((AUTO_ADV != 0) && blink_wrap && blink);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      phase     <= PH_WORK;
      mm        <= 7'(WORK_MIN);
      ss        <= '0;
      clk_cnt   <= '0;
      blink_cnt <= '0;
      blink     <= 1'b0;
      work_done <= '0;
      alarm     <= 1'b0;
    end else begin
      state     <= state_n;
      phase     <= phase_n;
      mm        <= mm_n;
      ss        <= ss_n;
      clk_cnt   <= clk_cnt_n;
      blink_cnt <= blink_cnt_n;
      blink     <= blink_n;
      work_done <= work_done_n;
      alarm     <= alarm_n;
    end
  end

  always_comb begin
    state_n     = state;
    phase_n     = phase;
    mm_n        = mm;
    ss_n        = ss;
    clk_cnt_n   = clk_cnt;
    blink_cnt_n = blink_cnt;
    blink_n     = blink;
    work_done_n = work_done;
    alarm_n     = 1'b0;

    case (state)
      ST_IDLE: begin
        blink_n = 1'b0;
        // lever wins; a simultaneous button pulse is dropped
        if (bus.lever) begin
          state_n   = ST_RUN;
          clk_cnt_n = '0;
        end else if (bus.button) begin
          state_n     = ST_SET;
          blink_cnt_n = '0;
          ss_n        = '0;
        end
      end

      ST_RUN: begin
        // zero is tested before counting so a run started at 00:00 expires
        // on the next clock without consuming a tick
        if (at_zero) begin
          state_n     = ST_EXPIRED;
          alarm_n     = 1'b1;
          blink_cnt_n = '0;
          blink_n     = 1'b0;
        end else if (bus.lever) begin
          // clk_cnt is held so resume finishes the partial second
          state_n     = ST_PAUSE;
          blink_cnt_n = '0;
          blink_n     = 1'b0;
        end else if (clk_cnt == TICK_LAST) begin
          clk_cnt_n = '0;
          if (ss == 6'd0) begin
            ss_n = SEC_WRAP;
            mm_n = mm - 7'd1;
          end else begin
            ss_n = ss - 6'd1;
          end
        end else begin
          clk_cnt_n = clk_cnt + TW'(1);
        end
      end

      ST_PAUSE: begin
        blink_cnt_n = blink_cnt_step;
        blink_n     = blink_step;
        if (bus.lever) begin
          state_n = ST_RUN;
          blink_n = 1'b0;
        end else if (bus.button) begin
          state_n   = ST_IDLE;
          blink_n   = 1'b0;
          mm_n      = preset(phase);
          ss_n      = '0;
          clk_cnt_n = '0;
        end
      end

      ST_SET: begin
        blink_cnt_n = blink_cnt_step;
        blink_n     = blink_step;
        ss_n        = '0;
        if (bus.lever) begin
          mm_n = (mm == 7'd0) ? 7'(MAX_MIN) : mm - 7'd1;
        end else if (bus.button) begin
          // the edited minutes stay as this phase's duration
          state_n = ST_IDLE;
          blink_n = 1'b0;
        end
      end

      ST_EXPIRED: begin
        blink_cnt_n = blink_cnt_step;
        blink_n     = blink_step;
        if (advance) begin
          if (phase == PH_WORK) begin
            if (work_inc == 4'(LONG_EVERY)) begin
              work_done_n = '0;
              phase_n     = PH_LONG;
            end else begin
              work_done_n = work_inc;
              phase_n     = PH_SHORT;
            end
          end else begin
            phase_n = PH_WORK;
          end
          mm_n      = preset(phase_n);
          ss_n      = '0;
          clk_cnt_n = '0;
          blink_n   = 1'b0;
          state_n   = (AUTO_ADV != 0) ? ST_RUN : ST_IDLE;
        end
      end

      default: begin
        state_n = ST_IDLE;
        blink_n = 1'b0;
      end
    endcase
  end

  pomo_cycle_engine_bin2bcd99 #(.RST_BIN(7'(WORK_MIN))) u_min_bcd (
    .clk (clk),
    .rst (rst),
    .bin (mm),
    .bcd (min_bcd)
  );

  pomo_cycle_engine_bin2bcd99 #(.RST_BIN(7'd0)) u_sec_bcd (
    .clk (clk),
    .rst (rst),
    .bin ({1'b0, ss}),
    .bcd (sec_bcd)
  );

  assign bus.min_bcd   = min_bcd;
  assign bus.sec_bcd   = sec_bcd;
  assign bus.blink_7sd = blink;
  assign bus.phase     = phase;
  assign bus.work_done = work_done;
  assign bus.alarm     = alarm;

endmodule
